usb_fifo_ctrl: RTL and testbench

Sequencing controller for the FT601-style 32-bit synchronous FIFO bus on the `lycan` top level. It owns the shared `usb_data`/`usb_be` bus and its strobes (`usb_rden_l`, `usb_wren_l`, `usb_outen_l`). It arbitrates between host→FPGA reads (RX) and FPGA→host writes (TX), with bus turnaround and per-grant burst limits. It presents RX data on a valid/ready stream through an internal buffer, and accepts TX data on a valid/ready stream. The top level builds the tristate pads from `usb_data_out`/`usb_data_oe`.

---
 rtl/lycan_pkg.sv | 15 +
 rtl/usb_rx_fifo.sv | 58 +++++
 rtl/usb_fifo_ctrl.sv | 162 ++++++++++++++++
 tb/tb_usb_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lycan_pkg.sv
// Shared types and bus constants for the lycan USB FIFO path.
package lycan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_READ,
    TX_WRITE,
    TURN
  } usb_state_t;

  localparam int USB_WIDTH    = 32;
  localparam int USB_BE_WIDTH = 4;

endpackage

// File: rtl/usb_rx_fifo.sv
// Synchronous RX buffer with first-word-fall-through output.
module usb_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // a push into a full buffer is only legal when a pop frees the slot
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/usb_fifo_ctrl.sv
// FT601-style 32-bit synchronous FIFO bus sequencer: RX/TX arbitration,
// bus turnaround and burst limiting.
//
// state    | meaning
// IDLE     | bus released, arbitrating RX vs TX
// RX_OE    | FT601 output enabled, read strobe next
// RX_READ  | read strobe low, capturing words
// TX_WRITE | FPGA drives bus from holding register
// TURN     | one dead cycle, nobody drives the bus
module usb_fifo_ctrl
  import lycan_pkg::*;
#(
  parameter int WIDTH     = USB_WIDTH,
  parameter int RX_DEPTH  = 8,
  parameter int MAX_BURST = 256
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [WIDTH-1:0]   usb_data_in,
  output logic [WIDTH-1:0]   usb_data_out,
  output logic               usb_data_oe,
  output logic [WIDTH/8-1:0] usb_be_out,
  input  logic               usb_rx_empty,
  input  logic               usb_tx_full,
  output logic               usb_rden_l,
  output logic               usb_wren_l,
  output logic               usb_outen_l,
  output logic [WIDTH-1:0]   rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  input  logic [WIDTH-1:0]   tx_data,
  input  logic               tx_valid,
  output logic               tx_ready
);

  localparam int BW = $clog2(MAX_BURST+1);
  localparam int CW = $clog2(RX_DEPTH+1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  // highest occupancy that still leaves room for two more words
  localparam logic [CW-1:0] RX_OCC_LIM = CW'(RX_DEPTH-2);

  usb_state_t       state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             last_rx_q, last_rx_d;
  logic             rden_l_q, rden_l_d;
  logic             wren_l_q, wren_l_d;
  logic             outen_l_q, outen_l_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  logic [CW-1:0]    rx_count, rx_occ_nxt;
  logic             rx_push, rx_pop, rx_req, tx_req, tx_accept;

  usb_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (rx_push),
    .push_data(usb_data_in),
    .pop      (rx_pop),
    .pop_data (rx_data),
    .count    (rx_count),
    .valid    (rx_valid)
  );

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    last_rx_d   = last_rx_q;
    rden_l_d    = 1'b1;
    wren_l_d    = 1'b1;
    outen_l_d   = 1'b1;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    rx_push     = 1'b0;
    tx_ready    = 1'b0;
    tx_accept   = 1'b0;
    rx_occ_nxt  = rx_count;
    rx_pop      = rx_valid && rx_ready;
    rx_req      = !usb_rx_empty && (rx_count <= RX_OCC_LIM);
    tx_req      = tx_valid && !usb_tx_full;

    case (state_q)
      IDLE: begin
        if (rx_req && (!tx_req || !last_rx_q)) begin
          state_d   = RX_OE;
          burst_d   = '0;
          last_rx_d = 1'b1;
          outen_l_d = 1'b0;
        end else if (tx_req) begin
          state_d   = TX_WRITE;
          burst_d   = '0;
          last_rx_d = 1'b0;
        end
      end
      RX_OE: begin
        state_d   = RX_READ;
        outen_l_d = 1'b0;
        rden_l_d  = 1'b0;
      end
      RX_READ: begin
        rx_push = !rden_l_q && !usb_rx_empty;
        if (rx_push) burst_d = burst_q + 1'b1;
        if (rx_push && !rx_pop)      rx_occ_nxt = rx_count + 1'b1;
        else if (!rx_push && rx_pop) rx_occ_nxt = rx_count - 1'b1;
        if (usb_rx_empty || (rx_occ_nxt > RX_OCC_LIM) || (burst_d == BURST_MAX)) begin
          state_d = TURN;
        end else begin
          rden_l_d  = 1'b0;
          outen_l_d = 1'b0;
        end
      end
      TX_WRITE: begin
        tx_accept = !wren_l_q && !usb_tx_full;
        tx_ready  = (!hold_full_q || tx_accept) && (burst_q < BURST_MAX);
        if (tx_valid && tx_ready) begin
          hold_data_d = tx_data;
          hold_full_d = 1'b1;
          burst_d     = burst_q + 1'b1;
        end else if (tx_accept) begin
          hold_full_d = 1'b0;
        end
        if (hold_full_d) wren_l_d = 1'b0;
        else             state_d  = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      last_rx_q   <= 1'b0;
      rden_l_q    <= 1'b1;
      wren_l_q    <= 1'b1;
      outen_l_q   <= 1'b1;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      last_rx_q   <= last_rx_d;
      rden_l_q    <= rden_l_d;
      wren_l_q    <= wren_l_d;
      outen_l_q   <= outen_l_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign usb_rden_l   = rden_l_q;
  assign usb_wren_l   = wren_l_q;
  assign usb_outen_l  = outen_l_q;
  assign usb_data_oe  = (state_q == TX_WRITE);
  assign usb_data_out = usb_data_oe ? hold_data_q : '0;
  assign usb_be_out   = '1;

endmodule

// File: tb/tb_usb_fifo_ctrl.sv
// Directed bench for usb_fifo_ctrl with a mock FT601 on each DUT instance.
module tb_usb_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l;
  logic [31:0] usb_data_in, usb_data_out, rx_data, tx_data;
  logic        usb_data_oe, usb_rx_empty, usb_tx_full;
  logic [3:0]  usb_be_out;
  logic        usb_rden_l, usb_wren_l, usb_outen_l;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;

  logic [31:0] a_data_in, a_data_out, a_rx_data, a_tx_data;
  logic        a_oe, a_rx_empty, a_tx_full;
  logic [3:0]  a_be;
  logic        a_rden_l, a_wren_l, a_outen_l;
  logic        a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready;

  int total = 0;
  int bad   = 0;

  int host_cnt = 0;
  int host_rd  = 0;
  int a_cnt    = 0;
  logic [31:0] rx_got[$];
  logic [31:0] tx_got[$];

  assign usb_rx_empty = (host_rd >= host_cnt);
  assign usb_data_in  = usb_rx_empty ? 32'h0 : 32'hA000_0000 + 32'(host_rd);
  assign a_data_in    = 32'hC000_0000 + 32'(a_cnt);
  assign a_tx_full    = 1'b0;
  assign a_rx_ready   = 1'b1;
  assign a_tx_data    = 32'h7777_0000;

  always @(posedge clk) begin
    if (!usb_rden_l && !usb_rx_empty) host_rd <= host_rd + 1;
    if (!a_rden_l && !a_rx_empty) a_cnt <= a_cnt + 1;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (!usb_wren_l && !usb_tx_full) tx_got.push_back(usb_data_out);
  end

  usb_fifo_ctrl dut (
    .clk(clk), .rst_l(rst_l),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out), .usb_data_oe(usb_data_oe),
    .usb_be_out(usb_be_out), .usb_rx_empty(usb_rx_empty), .usb_tx_full(usb_tx_full),
    .usb_rden_l(usb_rden_l), .usb_wren_l(usb_wren_l), .usb_outen_l(usb_outen_l),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  usb_fifo_ctrl #(.MAX_BURST(4)) dut_arb (
    .clk(clk), .rst_l(rst_l),
    .usb_data_in(a_data_in), .usb_data_out(a_data_out), .usb_data_oe(a_oe),
    .usb_be_out(a_be), .usb_rx_empty(a_rx_empty), .usb_tx_full(a_tx_full),
    .usb_rden_l(a_rden_l), .usb_wren_l(a_wren_l), .usb_outen_l(a_outen_l),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (usb_rden_l !== 1'b1)  begin bad++; $display("FAIL reset_rden_l got=%b want=1", usb_rden_l); end
    total++; if (usb_wren_l !== 1'b1)  begin bad++; $display("FAIL reset_wren_l got=%b want=1", usb_wren_l); end
    total++; if (usb_outen_l !== 1'b1) begin bad++; $display("FAIL reset_outen_l got=%b want=1", usb_outen_l); end
    total++; if (usb_data_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", usb_data_oe); end
    total++; if (usb_data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h want=0", usb_data_out); end
    total++; if (usb_be_out !== 4'hF) begin bad++; $display("FAIL reset_be got=%h want=f", usb_be_out); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (rx_data !== 32'h0) begin bad++; $display("FAIL reset_rx_data got=%h want=0", rx_data); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b want=0", tx_ready); end
    total++; if ({a_be, a_data_out, a_rx_data, a_rx_valid, a_tx_ready} !== {4'hF, 32'h0, 32'h0, 2'b00})
      begin bad++; $display("FAIL reset_arb_outputs got=%h/%h/%h/%b%b", a_be, a_data_out, a_rx_data, a_rx_valid, a_tx_ready); end
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (usb_outen_l !== 1'b1) begin bad++; $display("FAIL idle_outen_l got=%b want=1", usb_outen_l); end
  endtask

  task automatic test_rx_burst;
    int start, base, first_oe, first_val, rden_cnt, oe_cnt;
    logic [31:0] got;
    start = rx_got.size(); base = host_cnt;
    first_oe = -1; first_val = -1; rden_cnt = 0; oe_cnt = 0;
    @(negedge clk);
    rx_ready = 1'b1;
    host_cnt += 5;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!usb_rden_l) rden_cnt++;
      if (!usb_outen_l) begin oe_cnt++; if (first_oe < 0) first_oe = c; end
      if (rx_valid && first_val < 0) first_val = c;
    end
    total++; if (first_oe != 1)  begin bad++; $display("FAIL rx_outen_latency got=%0d want=1", first_oe); end
    total++; if (first_val != 3) begin bad++; $display("FAIL rx_valid_latency got=%0d want=3", first_val); end
    total++; if (rden_cnt != 6)  begin bad++; $display("FAIL rx_rden_cycles got=%0d want=6", rden_cnt); end
    total++; if (oe_cnt != 7)    begin bad++; $display("FAIL rx_outen_cycles got=%0d want=7", oe_cnt); end
    total++; if (rx_got.size() - start != 5) begin bad++; $display("FAIL rx_burst_count got=%0d want=5", rx_got.size() - start); end
    for (int i = 0; i < 5; i++) begin
      got = (start + i < rx_got.size()) ? rx_got[start + i] : 32'hxxxx_xxxx;
      total++; if (got !== 32'hA000_0000 + 32'(base + i))
        begin bad++; $display("FAIL rx_burst_word%0d got=%h want=%h", i, got, 32'hA000_0000 + 32'(base + i)); end
    end
  endtask

  task automatic test_rx_backpressure;
    int start, base, n;
    logic [31:0] got;
    start = rx_got.size(); base = host_cnt;
    @(negedge clk);
    rx_ready = 1'b0;
    host_cnt += 20;
    repeat (30) @(negedge clk);
    total++; if (host_rd - base != 7) begin bad++; $display("FAIL bp_captured got=%0d want=7", host_rd - base); end
    total++; if (usb_rden_l !== 1'b1) begin bad++; $display("FAIL bp_rden_released got=%b want=1", usb_rden_l); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL bp_rx_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 32'hA000_0000 + 32'(base))
      begin bad++; $display("FAIL bp_head_word got=%h want=%h", rx_data, 32'hA000_0000 + 32'(base)); end
    rx_ready = 1'b1;
    n = 0;
    while (rx_got.size() < start + 20 && n < 300) begin @(negedge clk); n++; end
    total++; if (rx_got.size() - start != 20) begin bad++; $display("FAIL bp_total got=%0d want=20", rx_got.size() - start); end
    for (int i = 0; i < 20; i++) begin
      got = (start + i < rx_got.size()) ? rx_got[start + i] : 32'hxxxx_xxxx;
      total++; if (got !== 32'hA000_0000 + 32'(base + i))
        begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got, 32'hA000_0000 + 32'(base + i)); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tx_full;
    int start, k;
    logic [31:0] got;
    start = tx_got.size(); k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      usb_tx_full = (c >= 4 && c <= 6);
      if (k < 4) begin tx_valid = 1'b1; tx_data = 32'h5000_0000 + 32'(k); end
      else begin tx_valid = 1'b0; tx_data = 32'h0; end
      #1;
      if (c == 1) begin
        total++; if (usb_wren_l !== 1'b1) begin bad++; $display("FAIL tx_first_wren got=%b want=1", usb_wren_l); end
      end
      if (c == 2) begin
        total++; if ({usb_wren_l, usb_data_oe, usb_data_out} !== {2'b01, 32'h5000_0000})
          begin bad++; $display("FAIL tx_latency got=%b%b/%h want=01/50000000", usb_wren_l, usb_data_oe, usb_data_out); end
      end
      if (c >= 4 && c <= 6) begin
        total++; if ({usb_wren_l, tx_ready, usb_data_out} !== {2'b00, 32'h5000_0002})
          begin bad++; $display("FAIL tx_hold_c%0d got=%b%b/%h want=00/50000002", c, usb_wren_l, tx_ready, usb_data_out); end
      end
      if (tx_valid && tx_ready) k++;
    end
    usb_tx_full = 1'b0;
    total++; if ({usb_wren_l, usb_data_oe} !== 2'b10) begin bad++; $display("FAIL tx_released got=%b%b want=10", usb_wren_l, usb_data_oe); end
    total++; if (tx_got.size() - start != 4) begin bad++; $display("FAIL tx_count got=%0d want=4", tx_got.size() - start); end
    for (int i = 0; i < 4; i++) begin
      got = (start + i < tx_got.size()) ? tx_got[start + i] : 32'hxxxx_xxxx;
      total++; if (got !== 32'h5000_0000 + 32'(i))
        begin bad++; $display("FAIL tx_word%0d got=%h want=%h", i, got, 32'h5000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid_burst;
    int n, rel, start, want_n;
    logic [31:0] got;
    @(negedge clk);
    rx_ready = 1'b0;
    host_cnt += 10;
    n = 0;
    while (usb_rden_l && n < 20) begin @(negedge clk); n++; end
    total++; if (usb_rden_l !== 1'b0) begin bad++; $display("FAIL rst_reach_read got=%b want=0", usb_rden_l); end
    repeat (2) @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b want=1", rx_valid); end
    #2 rst_l = 1'b0;
    #1;
    total++; if ({usb_rden_l, usb_wren_l, usb_outen_l, usb_data_oe, rx_valid} !== 5'b11100)
      begin bad++; $display("FAIL rst_async got=%b%b%b%b%b want=11100", usb_rden_l, usb_wren_l, usb_outen_l, usb_data_oe, rx_valid); end
    @(negedge clk);
    rel = host_rd;
    rst_l = 1'b1;
    @(negedge clk);
    total++; if ({usb_outen_l, usb_rden_l} !== 2'b01)
      begin bad++; $display("FAIL rst_restart_idle got=%b%b want=01", usb_outen_l, usb_rden_l); end
    start = rx_got.size();
    want_n = host_cnt - rel;
    rx_ready = 1'b1;
    n = 0;
    while (rx_got.size() < start + want_n && n < 100) begin @(negedge clk); n++; end
    total++; if (rx_got.size() - start != want_n) begin bad++; $display("FAIL rst_drain_count got=%0d want=%0d", rx_got.size() - start, want_n); end
    for (int i = 0; i < want_n; i++) begin
      got = (start + i < rx_got.size()) ? rx_got[start + i] : 32'hxxxx_xxxx;
      total++; if (got !== 32'hA000_0000 + 32'(rel + i))
        begin bad++; $display("FAIL rst_word%0d got=%h want=%h", i, got, 32'hA000_0000 + 32'(rel + i)); end
    end
  endtask

  task automatic test_arbitration;
    int kind_q[$], len_q[$], gap_q[$];
    int rlen, wlen, gap, clash, kind, len;
    bit seen;
    rlen = 0; wlen = 0; gap = 0; clash = 0; seen = 1'b0;
    @(negedge clk);
    a_rx_empty = 1'b0;
    a_tx_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (a_oe && !a_outen_l) clash++;
      if (!a_rden_l) rlen++;
      else if (rlen > 0) begin kind_q.push_back(0); len_q.push_back(rlen); rlen = 0; end
      if (!a_wren_l) wlen++;
      else if (wlen > 0) begin kind_q.push_back(1); len_q.push_back(wlen); wlen = 0; end
      if (!a_outen_l || a_oe) begin
        if (seen && gap > 0) gap_q.push_back(gap);
        seen = 1'b1; gap = 0;
      end else gap++;
    end
    a_rx_empty = 1'b1;
    a_tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (clash != 0) begin bad++; $display("FAIL arb_bus_clash got=%0d want=0", clash); end
    total++; if (kind_q.size() < 6) begin bad++; $display("FAIL arb_run_count got=%0d want>=6", kind_q.size()); end
    for (int i = 0; i < 6; i++) begin
      kind = (i < kind_q.size()) ? kind_q[i] : -1;
      len  = (i < len_q.size()) ? len_q[i] : -1;
      total++; if (kind != (i % 2) || len != 4)
        begin bad++; $display("FAIL arb_run%0d got=kind%0d/len%0d want=kind%0d/len4", i, kind, len, i % 2); end
    end
    for (int i = 0; i < 5; i++) begin
      gap = (i < gap_q.size()) ? gap_q[i] : -1;
      total++; if (gap != 2) begin bad++; $display("FAIL arb_turn_gap%0d got=%0d want=2", i, gap); end
    end
  endtask

  initial begin
    rst_l       = 1'b0;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 32'h0;
    usb_tx_full = 1'b0;
    a_rx_empty  = 1'b1;
    a_tx_valid  = 1'b0;
    test_reset;
    test_rx_burst;
    test_rx_backpressure;
    test_tx_full;
    test_reset_mid_burst;
    test_arbitration;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
